// File: rtl/parity_stream_tx.sv
// Stream source: FIFO-buffered words emitted as single-cycle valid pulses with even parity,
// paced by a fixed inter-word gap.
module parity_stream_tx #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_push,
    input  logic                     enable,
    input  logic                     force_bad,
    output logic                     in_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [WIDTH-1:0]         x_data,
    output logic                     x_valid,
    output logic                     x_parity
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [GW-1:0]    gap_cnt;
    logic             push_ok;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Fullness is judged before any same-cycle pop, so a push while full is always dropped.
    always_comb begin
        in_full = (level == LW'(DEPTH));
        push_ok = in_push && !in_full;
        pop     = enable && (level != '0) && (gap_cnt == '0);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            gap_cnt  <= '0;
            x_data   <= '0;
            x_valid  <= 1'b0;
            x_parity <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (in_push && in_full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                gap_cnt <= GW'(GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            // Bus is zeroed whenever no word is emitted.
            x_valid  <= pop;
            x_data   <= pop ? head : '0;
            x_parity <= pop ? ((^head) ^ force_bad) : 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_stream_tx.sv
// Randomised bench for parity_stream_tx: two instances (GAP=0 and GAP=2) against a queue model,
// plus directed literal checks.
module tb_parity_stream_tx;

    localparam int unsigned W = 16;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_push = 1'b0;
    logic         enable = 1'b0;
    logic         force_bad = 1'b0;
    logic         go = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned G = 2 * g;

        logic             in_full;
        logic [2:0]       level;
        logic             overflow;
        logic [W-1:0]     x_data;
        logic             x_valid;
        logic             x_parity;

        parity_stream_tx #(
            .WIDTH (W),
            .DEPTH (D),
            .GAP   (G)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data),
            .in_push   (in_push),
            .enable    (enable),
            .force_bad (force_bad),
            .in_full   (in_full),
            .level     (level),
            .overflow  (overflow),
            .x_data    (x_data),
            .x_valid   (x_valid),
            .x_parity  (x_parity)
        );

        logic [W-1:0] q[$];
        int           gap = 0;
        int           qn = 0;
        logic         ev = 1'b0;
        logic         ep = 1'b0;
        logic         ov = 1'b0;
        logic [W-1:0] ed = '0;

        // Model: pop decision uses pre-edge state, then the push lands behind it.
        always @(posedge clk) begin
            bit full;
            bit pop;
            if (rst) begin
                q.delete();
                gap = 0;
                ev = 1'b0;
                ed = '0;
                ep = 1'b0;
                ov = 1'b0;
            end else begin
                full = (q.size() == D);
                pop = enable && (q.size() > 0) && (gap == 0);
                if (pop) begin
                    ed = q.pop_front();
                    ev = 1'b1;
                    ep = (^ed) ^ force_bad;
                    gap = G;
                end else begin
                    ev = 1'b0;
                    ed = '0;
                    ep = 1'b0;
                    if (gap > 0) gap--;
                end
                if (in_push) begin
                    if (full) ov = 1'b1;
                    else q.push_back(in_data);
                end
            end
            qn = q.size();
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("valid0", 32'(lane[0].x_valid), 32'(lane[0].ev));
            chk("data0", 32'(lane[0].x_data), 32'(lane[0].ed));
            chk("parity0", 32'(lane[0].x_parity), 32'(lane[0].ep));
            chk("level0", 32'(lane[0].level), 32'(lane[0].qn));
            chk("full0", 32'(lane[0].in_full), 32'(lane[0].qn == D));
            chk("ovf0", 32'(lane[0].overflow), 32'(lane[0].ov));
            chk("valid2", 32'(lane[1].x_valid), 32'(lane[1].ev));
            chk("data2", 32'(lane[1].x_data), 32'(lane[1].ed));
            chk("parity2", 32'(lane[1].x_parity), 32'(lane[1].ep));
            chk("level2", 32'(lane[1].level), 32'(lane[1].qn));
            chk("full2", 32'(lane[1].in_full), 32'(lane[1].qn == D));
            chk("ovf2", 32'(lane[1].overflow), 32'(lane[1].ov));
        end
    end

    initial begin
        logic [8:0] pat;

        // Reset for two edges.
        repeat (2) @(negedge clk);
        go = 1'b1;
        chk("rst_valid", 32'(lane[0].x_valid), 32'd0);
        chk("rst_data", 32'(lane[0].x_data), 32'd0);
        chk("rst_level", 32'(lane[0].level), 32'd0);
        chk("rst_full", 32'(lane[0].in_full), 32'd0);
        chk("rst_ovf", 32'(lane[0].overflow), 32'd0);
        rst = 1'b0;

        // Single word: pulse two edges after the push.
        enable = 1'b1;
        in_data = 16'h0003;
        in_push = 1'b1;
        @(negedge clk);
        in_push = 1'b0;
        chk("lat_novalid", 32'(lane[0].x_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(lane[0].x_valid), 32'd1);
        chk("lat_data", 32'(lane[0].x_data), 32'h0003);
        chk("lat_par", 32'(lane[0].x_parity), 32'd0);
        @(negedge clk);
        chk("idle_valid", 32'(lane[0].x_valid), 32'd0);
        chk("idle_data", 32'(lane[0].x_data), 32'd0);

        // Back-to-back words, odd then even parity.
        in_data = 16'h0007;
        in_push = 1'b1;
        @(negedge clk);
        in_data = 16'h8001;
        @(negedge clk);
        in_push = 1'b0;
        chk("b2b_data_a", 32'(lane[0].x_data), 32'h0007);
        chk("b2b_par_a", 32'(lane[0].x_parity), 32'd1);
        @(negedge clk);
        chk("b2b_valid_b", 32'(lane[0].x_valid), 32'd1);
        chk("b2b_data_b", 32'(lane[0].x_data), 32'h8001);
        chk("b2b_par_b", 32'(lane[0].x_parity), 32'd0);

        // Fill with emission disabled, then overflow on the fifth push.
        enable = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_data = W'(i);
            in_push = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                chk("fill_full", 32'(lane[0].in_full), 32'd1);
                chk("fill_level", 32'(lane[0].level), 32'd4);
                chk("fill_noovf", 32'(lane[0].overflow), 32'd0);
            end
        end
        in_push = 1'b0;
        chk("ovf_set", 32'(lane[0].overflow), 32'd1);
        chk("ovf_level", 32'(lane[0].level), 32'd4);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("drain_valid", 32'(lane[0].x_valid), 32'd1);
            chk("drain_data", 32'(lane[0].x_data), 32'(i));
        end
        chk("drain_level", 32'(lane[0].level), 32'd0);
        @(negedge clk);
        chk("drain_done", 32'(lane[0].x_valid), 32'd0);

        // GAP=2 spacing on the second instance.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = W'(16'h0a00 + i);
            in_push = 1'b1;
            @(negedge clk);
        end
        in_push = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pat[i] = lane[1].x_valid;
        end
        chk("gap_pattern", 32'(pat), 32'h049);

        // Forced bad parity, then reset with words queued.
        enable = 1'b0;
        in_data = 16'h0003;
        in_push = 1'b1;
        @(negedge clk);
        in_push = 1'b0;
        enable = 1'b1;
        force_bad = 1'b1;
        @(negedge clk);
        force_bad = 1'b0;
        chk("bad_data", 32'(lane[0].x_data), 32'h0003);
        chk("bad_par", 32'(lane[0].x_parity), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = W'(16'h0100 + i);
            in_push = 1'b1;
            @(negedge clk);
        end
        in_push = 1'b0;
        chk("pre_rst_level", 32'(lane[0].level), 32'd3);
        rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", 32'(lane[0].x_valid), 32'd0);
        chk("rst_mid_level", 32'(lane[0].level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_quiet", 32'(lane[0].x_valid), 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            in_push = 1'($urandom_range(0, 1));
            in_data = W'($urandom);
            enable = ($urandom_range(0, 9) < 6);
            force_bad = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
